// File: rtl/mips_dmem_bridge.sv
// mips_dmem_bridge: data-memory front-end for the MIPS core data port.
// Takes one word load/store at a time from the core, replays it on a
// multi-cycle backing-memory bus, returns read data with a one-cycle
// completion pulse, and raises a sticky error when memory stops answering.
//
// Handshakes:
//   core side : core_req is held stable by the core until core_ready pulses;
//               a request is taken in IDLE only while halted is low.
//   mem side  : mem_req and all mem_* fields stay stable while BUSY until a
//               one-cycle mem_ack arrives; mem_rdata is valid with mem_ack.
//               mem_ack seen outside BUSY is ignored.
//
// Optional build macro MIPS_DMEM_READ_BUF_EN adds a one-entry read buffer
// (valid, word tag, data) that lets a repeated load complete without a
// memory access. Without the macro no buffer storage exists.
module mips_dmem_bridge #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            halted,
  input  logic            core_req,
  input  logic [XLEN-1:0] core_addr,
  input  logic            core_we,
  input  logic [3:0]      core_be,
  input  logic [XLEN-1:0] core_wdata,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_ready,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Last counter value before the bridge gives up on the memory.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] core_rdata_q, core_rdata_d;
  logic            core_ready_q, core_ready_d;
  logic            err_q, err_d;

  // Byte offset bits of the core address never reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_addr[1:0];

  // A new request is taken only from IDLE and only while the core runs.
  logic accept;
  assign accept = (state_q == ST_IDLE) && core_req && !halted;

`ifdef MIPS_DMEM_READ_BUF_EN
  logic            rb_valid_q, rb_valid_d;
  logic [XLEN-3:0] rb_tag_q, rb_tag_d;
  logic [XLEN-1:0] rb_data_q, rb_data_d;
  logic            rb_match;
  logic            buf_hit_load;

  // Buffer tag compare against the incoming word address.
  assign rb_match     = rb_valid_q && (rb_tag_q == core_addr[XLEN-1:2]);
  assign buf_hit_load = rb_match && !core_we;
`else
  logic buf_hit_load;
  assign buf_hit_load = 1'b0;
`endif

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    core_ready_d = 1'b0;
    err_d        = err_q;
`ifdef MIPS_DMEM_READ_BUF_EN
    rb_valid_d   = rb_valid_q;
    rb_tag_d     = rb_tag_q;
    rb_data_d    = rb_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (buf_hit_load) begin
`ifdef MIPS_DMEM_READ_BUF_EN
            // Buffered word: complete without touching memory.
            core_rdata_d = rb_data_q;
`endif
            core_ready_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = {core_addr[XLEN-1:2], 2'b00};
            mem_we_d    = core_we;
            mem_be_d    = core_be;
            mem_wdata_d = core_wdata;
            cnt_d       = 8'd0;
            state_d     = ST_BUSY;
`ifdef MIPS_DMEM_READ_BUF_EN
            // A store to the buffered word makes the copy stale.
            if (core_we && rb_match) begin
              rb_valid_d = 1'b0;
            end
`endif
          end
        end
      end

      ST_BUSY: begin
        if (mem_ack) begin
          // Ack wins over a same-cycle timeout.
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          core_ready_d = 1'b1;
          state_d      = ST_DONE;
          if (!mem_we_q) begin
            core_rdata_d = mem_rdata;
`ifdef MIPS_DMEM_READ_BUF_EN
            rb_valid_d = 1'b1;
            rb_tag_d   = mem_addr_q[XLEN-1:2];
            rb_data_d  = mem_rdata;
`endif
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // core_ready was high for this single cycle; go back for more work.
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        // Terminal until reset.
        err_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      core_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rdata_q <= core_rdata_d;
      core_ready_q <= core_ready_d;
      err_q        <= err_d;
    end
  end

`ifdef MIPS_DMEM_READ_BUF_EN
  // Read buffer registers; reset invalidates the entry.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      rb_valid_q <= 1'b0;
      rb_tag_q   <= '0;
      rb_data_q  <= '0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_tag_q   <= rb_tag_d;
      rb_data_q  <= rb_data_d;
    end
  end
`endif

  assign core_rdata = core_rdata_q;
  assign core_ready = core_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Bench for mips_dmem_bridge: directed scenarios with literal expectations,
// then randomized core/memory traffic against a transaction-level model.
module tb_mips_dmem_bridge;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
`ifdef MIPS_DMEM_READ_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_b;
  logic            halted;
  logic            core_req;
  logic [XLEN-1:0] core_addr;
  logic            core_we;
  logic [3:0]      core_be;
  logic [XLEN-1:0] core_wdata;
  logic [XLEN-1:0] core_rdata;
  logic            core_ready;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic            err;
  logic [1:0]      unused_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mips_dmem_bridge #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted), .core_req(core_req),
    .core_addr(core_addr), .core_we(core_we), .core_be(core_be),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .dbg_state(unused_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a request is either in flight at memory, just
  // completed (pulse cycle), or the bridge has given up for good.
  bit          m_inflight, m_pulse, m_err, t_we;
  int          m_age;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_we;
  logic [3:0]  e_be;
  bit          b_valid;
  logic [29:0] b_tag;
  logic [31:0] b_data;

  always @(posedge clk) begin
    logic [29:0] word;
    word = core_addr[31:2];
    if (rst_b) begin
      m_inflight = 0; m_pulse = 0; m_err = 0; m_age = 0; t_we = 0;
      e_addr = 0; e_wdata = 0; e_rdata = 0; e_we = 0; e_be = 0;
      b_valid = 0;
    end else if (m_err) begin
      m_pulse = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (m_inflight) begin
      if (mem_ack) begin
        m_inflight = 0; m_pulse = 1; e_we = 0; e_be = 0;
        if (!t_we) begin
          e_rdata = mem_rdata;
          b_valid = 1; b_tag = e_addr[31:2]; b_data = mem_rdata;
        end
      end else begin
        m_age++;
        if (m_age == TIMEOUT) begin m_inflight = 0; m_err = 1; end
      end
    end else if (core_req && !halted) begin
      if (BUF_EN && !core_we && b_valid && b_tag == word) begin
        m_pulse = 1; e_rdata = b_data;
      end else begin
        m_inflight = 1; m_age = 0; t_we = core_we;
        e_addr = {word, 2'b00}; e_we = core_we; e_be = core_be; e_wdata = core_wdata;
        if (core_we && b_valid && b_tag == word) b_valid = 0;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always begin
    @(posedge clk); #1;
    chk("mem_req",    {31'b0, mem_req},    {31'b0, m_inflight});
    chk("core_ready", {31'b0, core_ready}, {31'b0, m_pulse});
    chk("err",        {31'b0, err},        {31'b0, m_err});
    chk("mem_addr",   mem_addr,            e_addr);
    chk("mem_we",     {31'b0, mem_we},     {31'b0, e_we});
    chk("mem_be",     {28'b0, mem_be},     {28'b0, e_be});
    chk("mem_wdata",  mem_wdata,           e_wdata);
    chk("core_rdata", core_rdata,          e_rdata);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    core_addr = a; core_we = we; core_be = be; core_wdata = wd; core_req = 1'b1;
    step();
  endtask

  // Called right after acceptance; drives the ack in BUSY cycle ack_at
  // (0 = never) and returns how many edges after acceptance core_ready rose.
  task automatic wait_ready(input int ack_at, input logic [31:0] rd, output int lat);
    lat = 0;
    while (!core_ready && lat < 40) begin
      if (lat + 1 == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
      step();
      mem_ack = 1'b0;
      lat++;
    end
    if (!core_ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_wait: got no core_ready in 40 cycles, required a pulse");
    end
    core_req = 1'b0;
    step();
    chk("ready_one_cycle", {31'b0, core_ready}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    int bad;
    int busy_age;
    rst_b = 1; halted = 0; core_req = 1; core_addr = 0; core_we = 0;
    core_be = 4'hF; core_wdata = 0; mem_ack = 0; mem_rdata = 0;

    // Reset held two cycles with a request pending.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_mem_req",    {31'b0, mem_req}, 32'd0);
      chk("rst_core_ready", {31'b0, core_ready}, 32'd0);
      chk("rst_err",        {31'b0, err}, 32'd0);
      chk("rst_core_rdata", core_rdata, 32'd0);
    end
    rst_b = 0;
    step();
    chk("rel_mem_req", {31'b0, mem_req}, 32'd1);
    wait_ready(1, 32'h0000_0000, lat);

    // Load with ack in the third BUSY cycle.
    start_txn(32'h0000_0107, 1'b0, 4'hF, 32'h0);
    chk("ld_mem_req",  {31'b0, mem_req}, 32'd1);
    chk("ld_mem_addr", mem_addr, 32'h0000_0104);
    chk("ld_mem_we",   {31'b0, mem_we}, 32'd0);
    wait_ready(3, 32'hDEAD_BEEF, lat);
    chk("ld_latency", lat, 32'd3);
    chk("ld_rdata",   core_rdata, 32'hDEAD_BEEF);

    // Store with ack in the first BUSY cycle.
    start_txn(32'h0000_0200, 1'b1, 4'b0001, 32'h1122_3344);
    chk("st_mem_we",    {31'b0, mem_we}, 32'd1);
    chk("st_mem_be",    {28'b0, mem_be}, 32'd1);
    chk("st_mem_wdata", mem_wdata, 32'h1122_3344);
    chk("st_mem_addr",  mem_addr, 32'h0000_0200);
    wait_ready(1, 32'hCAFE_F00D, lat);
    chk("st_latency", lat, 32'd1);
    chk("st_rdata_kept", core_rdata, 32'hDEAD_BEEF);

    // Timeout: no ack ever.
    start_txn(32'h0000_0300, 1'b0, 4'hF, 32'h0);
    n = 0;
    while (!err && n < 40) begin step(); n++; end
    chk("to_cycles",  n, TIMEOUT);
    chk("to_mem_req", {31'b0, mem_req}, 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin step(); if (mem_req || core_ready) bad++; end
    chk("err_ignores_req", bad, 32'd0);
    chk("err_sticky", {31'b0, err}, 32'd1);
    core_req = 0; rst_b = 1;
    step();
    rst_b = 0;
    chk("err_cleared", {31'b0, err}, 32'd0);
    step();

    // halted blocks acceptance in IDLE but not completion in BUSY.
    halted = 1; core_addr = 32'h0000_0400; core_we = 0; core_be = 4'hF; core_req = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin step(); if (mem_req) bad++; end
    chk("halt_no_req", bad, 32'd0);
    halted = 0;
    step();
    chk("unhalt_req", {31'b0, mem_req}, 32'd1);
    halted = 1;
    wait_ready(2, 32'h55AA_55AA, lat);
    chk("halt_busy_lat",   lat, 32'd2);
    chk("halt_busy_rdata", core_rdata, 32'h55AA_55AA);
    halted = 0;

    // Repeated load, then store invalidation.
    start_txn(32'h0000_0104, 1'b0, 4'hF, 32'h0);
    chk("rb_fill_req", {31'b0, mem_req}, 32'd1);
    wait_ready(2, 32'h0BAD_F00D, lat);
    start_txn(32'h0000_0106, 1'b0, 4'hF, 32'h0);
`ifdef MIPS_DMEM_READ_BUF_EN
    chk("rb_hit_no_req", {31'b0, mem_req}, 32'd0);
    wait_ready(0, 32'h0, lat);
    chk("rb_hit_lat", lat, 32'd0);
    chk("rb_hit_data", core_rdata, 32'h0BAD_F00D);
`else
    chk("nobuf_req", {31'b0, mem_req}, 32'd1);
    wait_ready(1, 32'h1234_5678, lat);
    chk("nobuf_data", core_rdata, 32'h1234_5678);
`endif
    start_txn(32'h0000_0104, 1'b1, 4'hF, 32'hA5A5_A5A5);
    wait_ready(1, 32'h0, lat);
    start_txn(32'h0000_0104, 1'b0, 4'hF, 32'h0);
    chk("rb_inval_req", {31'b0, mem_req}, 32'd1);
    wait_ready(1, 32'h8765_4321, lat);
    chk("rb_inval_data", core_rdata, 32'h8765_4321);

    // Randomized traffic; the scoreboard checks every cycle.
    busy_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (rst_b) rst_b = 0;
      else if ($urandom_range(0, 399) == 0) rst_b = 1;
      halted = ($urandom_range(0, 3) == 0);
      if (!core_req || core_ready) begin
        if ($urandom_range(0, 2) != 0) begin
          core_req   = 1;
          core_addr  = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
          if ($urandom_range(0, 7) == 0) core_addr[31:24] = 8'($urandom());
          core_we    = ($urandom_range(0, 2) == 0);
          core_be    = 4'($urandom());
          core_wdata = $urandom();
        end else begin
          core_req = 0;
        end
      end
      mem_rdata = $urandom();
      if (mem_req) begin
        busy_age++;
        mem_ack = (busy_age >= 10) || ($urandom_range(0, 2) == 0);
        if (mem_ack) busy_age = 0;
      end else begin
        busy_age = 0;
        mem_ack = ($urandom_range(0, 7) == 0);
      end
    end
    core_req = 0; mem_ack = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
